// File: rtl/hi_lo_mult_div_sequencer.sv
// HI/LO multiply/divide sequencer for the execute stage.
// Iterative shift-add multiply and restoring divide; owns HI and LO.
module hi_lo_mult_div_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic                  start_execute,
  input  logic [1:0]            op_execute,
  input  logic [DATA_WIDTH-1:0] operand_a_execute,
  input  logic [DATA_WIDTH-1:0] operand_b_execute,
  input  logic                  hi_lo_write_execute,
  input  logic                  hi_lo_select_execute,
  input  logic                  hi_lo_read_execute,
  input  logic                  flush,
  output logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIN
  } state_e;

  state_e           state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     opb_q, opb_d;
  logic [W-1:0]     raw_a_q, raw_a_d;
  logic [1:0]       op_q, op_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic             done_q, done_d;

  logic             a_neg, b_neg;
  logic [W-1:0]     a_abs, b_abs;
  logic [W:0]       mul_sum;
  logic [W:0]       div_sh;
  logic [W:0]       div_diff;
  logic [2*W-1:0]   prod_fix;
  logic [W-1:0]     quo, rem;
  logic [W-1:0]     quo_fix, rem_fix;
  logic             last_iter;

  // op[0]=0 selects the signed variants
  assign a_neg = operand_a_execute[W-1] & ~op_execute[0];
  assign b_neg = operand_b_execute[W-1] & ~op_execute[0];
  assign a_abs = a_neg ? -operand_a_execute : operand_a_execute;
  assign b_abs = b_neg ? -operand_b_execute : operand_b_execute;

  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, opb_q};
  assign div_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff = div_sh - {1'b0, opb_q};

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo      = acc_q[W-1:0];
  assign rem      = acc_q[2*W-1:W];
  assign quo_fix  = neg_res_q ? -quo : quo;
  assign rem_fix  = neg_rem_q ? -rem : rem;

  assign last_iter = (cnt_q == COUNT_WIDTH'(W - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    raw_a_d   = raw_a_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!flush) begin
          if (start_execute) begin
            op_d      = op_execute;
            raw_a_d   = operand_a_execute;
            cnt_d     = '0;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            if (op_execute[1]) begin
              opb_d   = b_abs;
              acc_d   = {{W{1'b0}}, a_abs};
              state_d = S_DIV;
            end else begin
              opb_d   = a_abs;
              acc_d   = {{W{1'b0}}, b_abs};
              state_d = S_MUL;
            end
          end else if (hi_lo_write_execute) begin
            if (hi_lo_select_execute) hi_d = operand_a_execute;
            else                      lo_d = operand_a_execute;
          end
        end
      end
      S_MUL: begin
        acc_d = acc_q[0] ? {mul_sum, acc_q[W-1:1]}
                         : {1'b0, acc_q[2*W-1:1]};
        cnt_d = cnt_q + COUNT_WIDTH'(1);
        if (last_iter) state_d = S_FIN;
      end
      S_DIV: begin
        if (opb_q == '0) begin
          acc_d   = {raw_a_q, {W{1'b1}}};
          state_d = S_FIN;
        end else begin
          acc_d = div_diff[W]
                ? {div_sh[W-1:0], acc_q[W-2:0], 1'b0}
                : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
          cnt_d = cnt_q + COUNT_WIDTH'(1);
          if (last_iter) state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!op_q[1]) begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end else if (opb_q == '0) begin
          hi_d = rem;
          lo_d = quo;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // an abort leaves HI/LO untouched, even over the FIN write
    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      raw_a_q   <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      raw_a_q   <= raw_a_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign stall = busy & (start_execute | hi_lo_write_execute
                         | hi_lo_read_execute);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_hi_lo_mult_div_sequencer.sv
// Directed testbench for hi_lo_mult_div_sequencer.
// Each task drives one scenario and checks against hand-computed values.
module tb_hi_lo_mult_div_sequencer;

  logic        clk = 1'b0;
  logic        clear_n;
  logic        start_execute;
  logic [1:0]  op_execute;
  logic [31:0] operand_a_execute;
  logic [31:0] operand_b_execute;
  logic        hi_lo_write_execute;
  logic        hi_lo_select_execute;
  logic        hi_lo_read_execute;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  hi_lo_mult_div_sequencer #(
    .DATA_WIDTH (32),
    .COUNT_WIDTH(6)
  ) dut (
    .clk                 (clk),
    .clear_n             (clear_n),
    .start_execute       (start_execute),
    .op_execute          (op_execute),
    .operand_a_execute   (operand_a_execute),
    .operand_b_execute   (operand_b_execute),
    .hi_lo_write_execute (hi_lo_write_execute),
    .hi_lo_select_execute(hi_lo_select_execute),
    .hi_lo_read_execute  (hi_lo_read_execute),
    .flush               (flush),
    .stall               (stall),
    .busy                (busy),
    .done                (done),
    .hi                  (hi),
    .lo                  (lo)
  );

  always #5 clk = ~clk;

  // Drive one start for a single cycle; returns at the first negedge after E0.
  task automatic start_op(input logic [1:0] o,
                          input logic [31:0] x,
                          input logic [31:0] y);
    @(negedge clk);
    start_execute     = 1'b1;
    op_execute        = o;
    operand_a_execute = x;
    operand_b_execute = y;
    @(negedge clk);
    start_execute     = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic mt_write(input logic sel, input logic [31:0] v);
    @(negedge clk);
    hi_lo_write_execute  = 1'b1;
    hi_lo_select_execute = sel;
    operand_a_execute    = v;
    @(negedge clk);
    hi_lo_write_execute  = 1'b0;
  endtask

  task automatic test_reset;
    clear_n              = 1'b0;
    start_execute        = 1'b0;
    op_execute           = 2'b00;
    operand_a_execute    = '0;
    operand_b_execute    = '0;
    hi_lo_write_execute  = 1'b0;
    hi_lo_select_execute = 1'b0;
    hi_lo_read_execute   = 1'b0;
    flush                = 1'b0;
    #12;
    checks++;
    if ({hi, lo, busy, done, stall} !== 67'd0) begin
      errors++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b stall=%b, want all 0",
               hi, lo, busy, done, stall);
    end
    @(negedge clk);
    clear_n = 1'b1;
  endtask

  task automatic test_mult;
    int cyc, bcnt;
    start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 33 || bcnt !== 33) begin
      errors++;
      $display("FAIL mult_latency: cyc=%0d busy=%0d, want 33/33", cyc, bcnt);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mult_result: hi=%h lo=%h, want ffffffff/ffffffeb", hi, lo);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mult_done_pulse: done=%b busy=%b, want 0/0", done, busy);
    end
  endtask

  task automatic test_div;
    int cyc, bcnt;
    start_op(2'b11, 32'd100, 32'd7);
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 33 || lo !== 32'd14 || hi !== 32'd2) begin
      errors++;
      $display("FAIL divu: cyc=%0d lo=%h hi=%h, want 33/e/2", cyc, lo, hi);
    end
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc, bcnt);
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL div_signed: lo=%h hi=%h, want fffffffd/ffffffff", lo, hi);
    end
  endtask

  task automatic test_div_zero;
    int cyc, bcnt;
    start_op(2'b10, 32'h0000_1234, 32'd0);
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 2 || bcnt !== 2) begin
      errors++;
      $display("FAIL div0_latency: cyc=%0d busy=%0d, want 2/2", cyc, bcnt);
    end
    checks++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'h0000_1234) begin
      errors++;
      $display("FAIL div0_result: lo=%h hi=%h, want ffffffff/1234", lo, hi);
    end
  endtask

  task automatic test_stall;
    int n, bad;
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    hi_lo_read_execute = 1'b1;
    n   = 0;
    bad = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy !== 1'b1 || stall !== 1'b1) bad++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (bad !== 0 || n !== 33) begin
      errors++;
      $display("FAIL stall_busy: bad=%0d cycles=%0d, want 0/33", bad, n);
    end
    checks++;
    if (stall !== 1'b0 || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      errors++;
      $display("FAIL stall_after: stall=%b hi=%h lo=%h, want 0/fffffffe/1",
               stall, hi, lo);
    end
    hi_lo_read_execute = 1'b0;
  endtask

  task automatic test_priority;
    int cyc, bcnt;
    @(negedge clk);
    start_execute        = 1'b1;
    hi_lo_write_execute  = 1'b1;
    hi_lo_select_execute = 1'b1;
    op_execute           = 2'b01;
    operand_a_execute    = 32'd3;
    operand_b_execute    = 32'd5;
    @(negedge clk);
    start_execute        = 1'b0;
    hi_lo_write_execute  = 1'b0;
    checks++;
    if (hi !== 32'hFFFF_FFFE || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_priority: hi=%h busy=%b, want fffffffe/1", hi, busy);
    end
    wait_done(cyc, bcnt);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd15) begin
      errors++;
      $display("FAIL priority_result: hi=%h lo=%h, want 0/f", hi, lo);
    end
  endtask

  task automatic test_flush;
    int seen;
    mt_write(1'b1, 32'h0000_AAAA);
    mt_write(1'b0, 32'h0000_5555);
    checks++;
    if (hi !== 32'h0000_AAAA || lo !== 32'h0000_5555) begin
      errors++;
      $display("FAIL mthi_mtlo: hi=%h lo=%h, want aaaa/5555", hi, lo);
    end
    start_op(2'b00, 32'd9, 32'd9);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0000_AAAA || lo !== 32'h0000_5555) begin
      errors++;
      $display("FAIL flush_abort: busy=%b hi=%h lo=%h, want 0/aaaa/5555",
               busy, hi, lo);
    end
    seen = 0;
    repeat (40) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0 || hi !== 32'h0000_AAAA) begin
      errors++;
      $display("FAIL flush_no_done: activity=%0d hi=%h, want 0/aaaa", seen, hi);
    end
  endtask

  task automatic test_flush_idle;
    @(negedge clk);
    flush                = 1'b1;
    start_execute        = 1'b1;
    op_execute           = 2'b01;
    operand_a_execute    = 32'd2;
    operand_b_execute    = 32'd2;
    @(negedge clk);
    start_execute        = 1'b0;
    hi_lo_write_execute  = 1'b1;
    hi_lo_select_execute = 1'b1;
    operand_a_execute    = 32'h1111_1111;
    @(negedge clk);
    hi_lo_write_execute  = 1'b0;
    flush                = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0000_AAAA) begin
      errors++;
      $display("FAIL flush_idle: busy=%b hi=%h, want 0/aaaa", busy, hi);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, bcnt;
    start_op(2'b11, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    #2;
    clear_n = 1'b0;
    #1;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: hi=%h lo=%h busy=%b done=%b, want 0",
               hi, lo, busy, done);
    end
    @(negedge clk);
    clear_n = 1'b1;
    start_op(2'b01, 32'd3, 32'd5);
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 33 || lo !== 32'd15 || hi !== 32'd0) begin
      errors++;
      $display("FAIL post_reset_multu: cyc=%0d lo=%h hi=%h, want 33/f/0",
               cyc, lo, hi);
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_stall;
    test_priority;
    test_flush;
    test_flush_idle;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
